// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used by the pipeline control logic.
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Pipeline-control types: controller FSM states and the bundled enable/flush word.
package diaosi_types_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    // pipe_en[0] is IF/ID through pipe_en[3] MEM/WB; flush[0] is IF/ID through flush[2] EX/MEM
    typedef struct packed {
        logic       pc_en;
        logic [3:0] pipe_en;
        logic [2:0] flush;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_IDLE = '0;

    function automatic ctrl_out_t make_ctrl(input logic       pc_en,
                                            input logic [3:0] pipe_en,
                                            input logic [2:0] flush);
        ctrl_out_t c;
        c.pc_en   = pc_en;
        c.pipe_en = pipe_en;
        c.flush   = flush;
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of hazard/status inputs and stage enable/flush outputs shared between
// the pipeline controller and the datapath stage registers.
interface pipe_ctrl_if;
    import cpu_types_pkg::*;

    logic        ihit;
    logic        dhit;
    logic        mem_ren;
    logic        mem_wen;
    logic        ex_ren;
    regbits_t    ex_wsel;
    regbits_t    id_rsel1;
    regbits_t    id_rsel2;
    logic        redirect;
    logic        halt_mem;

    logic        pc_en;
    logic        pipe1_en;
    logic        pipe2_en;
    logic        pipe3_en;
    logic        pipe4_en;
    logic        flushed1;
    logic        flushed2;
    logic        flushed3;
    logic        halt;
    logic [15:0] stall_cnt;

    modport master (
        input  ihit, dhit, mem_ren, mem_wen, ex_ren, ex_wsel,
               id_rsel1, id_rsel2, redirect, halt_mem,
        output pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en,
               flushed1, flushed2, flushed3, halt, stall_cnt
    );

    modport slave (
        output ihit, dhit, mem_ren, mem_wen, ex_ren, ex_wsel,
               id_rsel1, id_rsel2, redirect, halt_mem,
        input  pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en,
               flushed1, flushed2, flushed3, halt, stall_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard: the load in ID/EX writes a register the IF/ID instruction reads.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_ren_i,
    input  regbits_t ex_wsel_i,
    input  regbits_t id_rsel1_i,
    input  regbits_t id_rsel2_i,
    output logic     load_use_o
);

    logic wsel_nonzero;
    logic rsel_match;

    // $zero is never a real producer, so a load targeting it cannot hazard
    assign wsel_nonzero = (ex_wsel_i != '0);
    assign rsel_match   = (ex_wsel_i == id_rsel1_i) | (ex_wsel_i == id_rsel2_i);
    assign load_use_o   = ex_ren_i & wsel_nonzero & rsel_match;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: stage enables/flushes from hazards and a
// RUN -> DRAIN -> HALTED shutdown sequence, plus a saturating IF/ID stall counter.
module pipe_ctrl
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic        ex_ren,
    input  regbits_t    ex_wsel,
    input  regbits_t    id_rsel1,
    input  regbits_t    id_rsel2,
    input  logic        redirect,
    input  logic        halt_mem,
    output logic        pc_en,
    output logic        pipe1_en,
    output logic        pipe2_en,
    output logic        pipe3_en,
    output logic        pipe4_en,
    output logic        flushed1,
    output logic        flushed2,
    output logic        flushed3,
    output logic        halt,
    output logic [15:0] stall_cnt
);

    ctrl_state_t state_q, state_d;
    logic        halt_q, halt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        mem_wait;
    logic        load_use;
    ctrl_out_t   ctrl;

    assign mem_wait = (mem_ren | mem_wen) & ~dhit;

    hazard_detect u_hazard (
        .ex_ren_i   (ex_ren),
        .ex_wsel_i  (ex_wsel),
        .id_rsel1_i (id_rsel1),
        .id_rsel2_i (id_rsel2),
        .load_use_o (load_use)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // A pending data access freezes everything, so a redirect waits for dhit
    always_comb begin
        state_d = state_q;
        ctrl    = CTRL_IDLE;
        unique case (state_q)
            RUN: begin
                if (mem_wait) begin
                    ctrl = make_ctrl(1'b0, 4'b0000, 3'b000);
                end else if (halt_mem) begin
                    ctrl    = make_ctrl(1'b0, 4'b1111, 3'b111);
                    state_d = DRAIN;
                end else if (redirect) begin
                    ctrl = make_ctrl(1'b1, 4'b1111, 3'b111);
                end else if (load_use || !ihit) begin
                    ctrl = make_ctrl(1'b0, 4'b1110, 3'b010);
                end else begin
                    ctrl = make_ctrl(1'b1, 4'b1111, 3'b000);
                end
            end
            DRAIN: begin
                ctrl    = make_ctrl(1'b0, 4'b1000, 3'b000);
                state_d = HALTED;
            end
            HALTED: begin
                ctrl = CTRL_IDLE;
            end
            default: begin
                ctrl    = CTRL_IDLE;
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        halt_d      = halt_q | (state_q == DRAIN);
        stall_cnt_d = stall_cnt_q;
        if (state_q == RUN && !ctrl.pipe_en[0] && stall_cnt_q != STALL_MAX) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign pc_en     = ctrl.pc_en;
    assign pipe1_en  = ctrl.pipe_en[0];
    assign pipe2_en  = ctrl.pipe_en[1];
    assign pipe3_en  = ctrl.pipe_en[2];
    assign pipe4_en  = ctrl.pipe_en[3];
    assign flushed1  = ctrl.flush[0];
    assign flushed2  = ctrl.flush[1];
    assign flushed3  = ctrl.flush[2];
    assign halt      = halt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expected controls,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

    typedef struct {
        string       name;
        logic [4:0]  en;
        logic [2:0]  fl;
        logic        halt;
        logic [15:0] stall;
    } expect_t;

    logic        clk = 1'b0;
    logic        nRst;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] expStall = '0;
    expect_t     expQ[$];

    pipe_ctrl_if pif();

    pipe_ctrl dut (
        .CLK       (clk),
        .nRST      (nRst),
        .ihit      (pif.ihit),
        .dhit      (pif.dhit),
        .mem_ren   (pif.mem_ren),
        .mem_wen   (pif.mem_wen),
        .ex_ren    (pif.ex_ren),
        .ex_wsel   (pif.ex_wsel),
        .id_rsel1  (pif.id_rsel1),
        .id_rsel2  (pif.id_rsel2),
        .redirect  (pif.redirect),
        .halt_mem  (pif.halt_mem),
        .pc_en     (pif.pc_en),
        .pipe1_en  (pif.pipe1_en),
        .pipe2_en  (pif.pipe2_en),
        .pipe3_en  (pif.pipe3_en),
        .pipe4_en  (pif.pipe4_en),
        .flushed1  (pif.flushed1),
        .flushed2  (pif.flushed2),
        .flushed3  (pif.flushed3),
        .halt      (pif.halt),
        .stall_cnt (pif.stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic setIdle();
        pif.ihit     = 1'b1;
        pif.dhit     = 1'b0;
        pif.mem_ren  = 1'b0;
        pif.mem_wen  = 1'b0;
        pif.ex_ren   = 1'b0;
        pif.ex_wsel  = 5'd0;
        pif.id_rsel1 = 5'd0;
        pif.id_rsel2 = 5'd0;
        pif.redirect = 1'b0;
        pif.halt_mem = 1'b0;
    endtask

    // en = {pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en}; fl = {flushed1, flushed2, flushed3}
    task automatic pushExpect(input string name, input logic [4:0] en,
                              input logic [2:0] fl, input logic halt);
        expect_t e;
        e.name  = name;
        e.en    = en;
        e.fl    = fl;
        e.halt  = halt;
        e.stall = expStall;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input string name, input logic [4:0] en,
                                 input logic [2:0] fl, input logic halt,
                                 input logic runStall);
        pushExpect(name, en, fl, halt);
        @(posedge clk);
        #1;
        if (runStall && expStall != 16'hFFFF) expStall = expStall + 16'd1;
    endtask

    task automatic compareField(input string name, input string field,
                                input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %h expected %h at %0t", name, field, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        compareField(e.name, "enables",
                     {11'd0, pif.pc_en, pif.pipe1_en, pif.pipe2_en, pif.pipe3_en, pif.pipe4_en},
                     {11'd0, e.en});
        compareField(e.name, "flushes",
                     {13'd0, pif.flushed1, pif.flushed2, pif.flushed3}, {13'd0, e.fl});
        compareField(e.name, "halt", {15'd0, pif.halt}, {15'd0, e.halt});
        compareField(e.name, "stall_cnt", pif.stall_cnt, e.stall);
    endtask

    always @(negedge clk) begin
        while (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    initial begin
        nRst = 1'b0;
        setIdle();
        #2;
        pushExpect("reset", 5'b11111, 3'b000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        nRst = 1'b1;

        // instruction cache miss for two cycles
        pif.ihit = 1'b0;
        applyStimulus("imiss_c1", 5'b00111, 3'b010, 1'b0, 1'b1);
        applyStimulus("imiss_c2", 5'b00111, 3'b010, 1'b0, 1'b1);
        setIdle();
        applyStimulus("imiss_after", 5'b11111, 3'b000, 1'b0, 1'b0);

        // load-use hazards
        pif.ex_ren = 1'b1; pif.ex_wsel = 5'd8; pif.id_rsel2 = 5'd8;
        applyStimulus("lu_rt", 5'b00111, 3'b010, 1'b0, 1'b1);
        pif.ex_wsel = 5'd0; pif.id_rsel1 = 5'd0; pif.id_rsel2 = 5'd0;
        applyStimulus("lu_zero", 5'b11111, 3'b000, 1'b0, 1'b0);
        pif.ex_wsel = 5'd5; pif.id_rsel1 = 5'd5; pif.id_rsel2 = 5'd9;
        applyStimulus("lu_rs", 5'b00111, 3'b010, 1'b0, 1'b1);
        pif.ex_ren = 1'b0;
        applyStimulus("lu_noload", 5'b11111, 3'b000, 1'b0, 1'b0);

        // priority between redirect, load-use and icache miss
        setIdle();
        pif.redirect = 1'b1; pif.ihit = 1'b0;
        applyStimulus("redir_imiss", 5'b11111, 3'b111, 1'b0, 1'b0);
        pif.ihit = 1'b1; pif.ex_ren = 1'b1; pif.ex_wsel = 5'd3; pif.id_rsel1 = 5'd3;
        applyStimulus("redir_lu", 5'b11111, 3'b111, 1'b0, 1'b0);
        pif.redirect = 1'b0; pif.ihit = 1'b0;
        applyStimulus("lu_imiss", 5'b00111, 3'b010, 1'b0, 1'b1);

        // dcache wait overriding a redirect, then the redirect on dhit
        setIdle();
        pif.mem_ren = 1'b1; pif.redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus("dwait_redir", 5'b00000, 3'b000, 1'b0, 1'b1);
        end
        pif.dhit = 1'b1;
        applyStimulus("dhit_redir", 5'b11111, 3'b111, 1'b0, 1'b0);
        setIdle();
        pif.mem_wen = 1'b1;
        applyStimulus("dwait_store", 5'b00000, 3'b000, 1'b0, 1'b1);
        pif.mem_wen = 1'b0; pif.mem_ren = 1'b1; pif.dhit = 1'b1;
        applyStimulus("dhit_load", 5'b11111, 3'b000, 1'b0, 1'b0);

        // halt held off by a data wait, then drain and halt
        setIdle();
        pif.halt_mem = 1'b1; pif.mem_ren = 1'b1;
        applyStimulus("halt_dwait", 5'b00000, 3'b000, 1'b0, 1'b1);
        pif.dhit = 1'b1;
        applyStimulus("halt_mem", 5'b01111, 3'b111, 1'b0, 1'b0);
        setIdle();
        applyStimulus("drain", 5'b00001, 3'b000, 1'b0, 1'b0);
        applyStimulus("halted", 5'b00000, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            pif.ihit     = (i % 2 == 0);
            pif.redirect = (i % 2 != 0);
            applyStimulus("halted_hold", 5'b00000, 3'b000, 1'b1, 1'b0);
        end

        // asynchronous reset between edges while halted
        #1;
        nRst = 1'b0;
        setIdle();
        expStall = '0;
        pushExpect("async_rst", 5'b11111, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        nRst = 1'b1;
        applyStimulus("rst_release", 5'b11111, 3'b000, 1'b0, 1'b0);
        pif.ihit = 1'b0;
        applyStimulus("rst_run_stall", 5'b00111, 3'b010, 1'b0, 1'b1);
        setIdle();
        applyStimulus("rst_run_cnt", 5'b11111, 3'b000, 1'b0, 1'b0);

        // long icache miss saturates the counter
        pif.ihit = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        expStall = 16'hFFFF;
        applyStimulus("sat_c1", 5'b00111, 3'b010, 1'b0, 1'b1);
        applyStimulus("sat_c2", 5'b00111, 3'b010, 1'b0, 1'b1);
        setIdle();
        applyStimulus("sat_hold", 5'b11111, 3'b000, 1'b0, 1'b0);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_queue: got %0d pending expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
